// File: rtl/multi_channel_clock_divider_if.sv
// Control/status bundle for the multi-channel clock divider.
// The master drives enables, sync and divisor writes; the slave returns ticks, clocks and write status.
interface multi_channel_clock_divider_if #(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned DIV_W = 32,
  parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             load_valid;
  logic [CH_W-1:0]  load_ch;
  logic [DIV_W-1:0] load_div;
  logic             load_ready;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  pending;

  modport master (
    output en, sync, load_valid, load_ch, load_div,
    input  load_ready, tick, clk_out, pending
  );

  modport slave (
    input  en, sync, load_valid, load_ch, load_div,
    output load_ready, tick, clk_out, pending
  );
endinterface

// File: rtl/multi_channel_clock_divider.sv
// N_CH independent runtime-programmable clock dividers with tick strobes and 50% square outputs.
// Divisor writes are staged and only take effect at a period boundary, sync, or while a channel is idle.
module multi_channel_clock_divider #(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned DIV_W   = 32,
  parameter int unsigned DEF_DIV = 250000,
  parameter int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input logic                          clk,
  input logic                          rst,
  multi_channel_clock_divider_if.slave bus
);
  localparam int unsigned     N_SLOT    = 1 << CH_W;
  localparam logic [DIV_W-1:0] DEF_DIV_W = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic [DIV_W-1:0]  count      [N_CH];
  logic [DIV_W-1:0]  active_div [N_CH];
  logic [DIV_W-1:0]  pend_div   [N_CH];
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   pending;
  logic [N_SLOT-1:0] ready_slot;
  logic [N_CH-1:0]   write_hit;

  // Out-of-range channel slots always report ready so such writes drain and are dropped.
  always_comb begin
    ready_slot             = '1;
    ready_slot[N_CH-1:0]   = ~pending;
  end

  assign bus.load_ready = ready_slot[bus.load_ch];

  always_comb begin
    write_hit = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      write_hit[i] = bus.load_valid && ready_slot[bus.load_ch] && (bus.load_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        count[i]      <= '0;
        active_div[i] <= DEF_DIV_W;
        pend_div[i]   <= '0;
      end
      tick    <= '0;
      clk_out <= '0;
      pending <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (bus.sync) begin
          count[i]   <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          if (pending[i]) begin
            active_div[i] <= pend_div[i];
            pending[i]    <= 1'b0;
          end
        end else if ((active_div[i] == '0) || !bus.en[i]) begin
          // Idle channel: hold phase, but accept a staged divisor straight away.
          tick[i] <= 1'b0;
          if (active_div[i] == '0) begin
            count[i] <= '0;
          end
          if (pending[i]) begin
            active_div[i] <= pend_div[i];
            count[i]      <= '0;
            pending[i]    <= 1'b0;
          end
        end else if (count[i] == active_div[i] - ONE) begin
          count[i]   <= '0;
          tick[i]    <= 1'b1;
          clk_out[i] <= ~clk_out[i];
          if (pending[i]) begin
            active_div[i] <= pend_div[i];
            pending[i]    <= 1'b0;
          end
        end else begin
          count[i] <= count[i] + ONE;
          tick[i]  <= 1'b0;
        end

        // A write seen this cycle is staged only; the boundary above still used the old divisor.
        if (write_hit[i]) begin
          pend_div[i] <= bus.load_div;
          pending[i]  <= 1'b1;
        end
      end
    end
  end

  assign bus.tick    = tick;
  assign bus.clk_out = clk_out;
  assign bus.pending = pending;
endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Scoreboard bench for multi_channel_clock_divider: directed scenarios then random traffic,
// checked against a remaining-cycles reference model of each channel.
module tb_multi_channel_clock_divider;
  localparam int NCH = 3;
  localparam int DEFD = 4;

  typedef struct packed {
    logic       ready;
    logic [2:0] tick;
    logic [2:0] clk_out;
    logic [2:0] pending;
  } exp_t;

  logic clk;
  logic rst;

  multi_channel_clock_divider_if #(.N_CH(3), .DIV_W(32), .CH_W(2)) bus ();

  multi_channel_clock_divider #(
    .N_CH(3), .DIV_W(32), .DEF_DIV(DEFD), .CH_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];

  // Reference model: per channel, enabled cycles remaining until the next tick.
  int m_div  [NCH];
  int m_rem  [NCH];
  bit m_lvl  [NCH];
  bit m_tick [NCH];
  bit m_pend [NCH];
  int m_pval [NCH];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, expv);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DEFD; m_rem[i] = DEFD; m_lvl[i] = 0;
      m_tick[i] = 0; m_pend[i] = 0; m_pval[i] = 0;
    end
  endtask

  task automatic model_apply(input int i);
    m_div[i]  = m_pval[i];
    m_pend[i] = 0;
  endtask

  task automatic model_step(input logic [2:0] e, input logic s, input logic lv,
                            input logic [1:0] lc, input logic [31:0] ld, output exp_t x);
    int idx;
    bit hit;
    idx = int'(lc);
    x.ready = (idx < NCH) ? !m_pend[idx] : 1'b1;
    hit = lv && x.ready && (idx < NCH);
    for (int i = 0; i < NCH; i++) begin
      if (s) begin
        if (m_pend[i]) model_apply(i);
        m_rem[i] = m_div[i]; m_lvl[i] = 0; m_tick[i] = 0;
      end else if (m_div[i] == 0 || !e[i]) begin
        m_tick[i] = 0;
        if (m_pend[i]) begin
          model_apply(i);
          m_rem[i] = m_div[i];
        end
      end else begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_tick[i] = 1;
          m_lvl[i]  = !m_lvl[i];
          if (m_pend[i]) model_apply(i);
          m_rem[i] = m_div[i];
        end else begin
          m_tick[i] = 0;
        end
      end
    end
    if (hit) begin
      m_pend[idx] = 1;
      m_pval[idx] = int'(ld);
    end
    for (int i = 0; i < NCH; i++) begin
      x.tick[i]    = m_tick[i];
      x.clk_out[i] = m_lvl[i];
      x.pending[i] = m_pend[i];
    end
  endtask

  // Drive one cycle of inputs (at posedge+2), queue the expected result of the coming edge.
  task automatic step(input logic [2:0] e, input logic s, input logic lv,
                      input logic [1:0] lc, input logic [31:0] ld);
    exp_t x;
    bus.en = e; bus.sync = s; bus.load_valid = lv; bus.load_ch = lc; bus.load_div = ld;
    model_step(e, s, lv, lc, ld, x);
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(3'b111, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  // Monitor: ready is sampled mid-cycle, registered outputs just after the edge.
  initial begin
    logic rdy_s;
    exp_t x;
    forever begin
      @(negedge clk);
      rdy_s = bus.load_ready;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("load_ready", {2'b00, rdy_s}, {2'b00, x.ready});
        chk("tick", bus.tick, x.tick);
        chk("clk_out", bus.clk_out, x.clk_out);
        chk("pending", bus.pending, x.pending);
      end
    end
  end

  initial begin
    logic [2:0] e;
    logic       s;
    logic       lv;
    logic [1:0] lc;
    logic [31:0] ld;
    int guard;

    rst = 1'b1;
    bus.en = 3'b111; bus.sync = 1'b0; bus.load_valid = 1'b0; bus.load_ch = 2'd0; bus.load_div = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tick", bus.tick, 3'b000);
    chk("reset_clk_out", bus.clk_out, 3'b000);
    chk("reset_pending", bus.pending, 3'b000);
    #1;
    rst = 1'b0;

    // Free-running default divide-by-4.
    idle(4);
    chk("first_tick", bus.tick, 3'b111);
    chk("first_clk_out_high", bus.clk_out, 3'b111);
    idle(4);
    chk("second_tick", bus.tick, 3'b111);
    chk("second_clk_out_low", bus.clk_out, 3'b000);

    // ch1 divisor change written while count=2.
    idle(2);
    step(3'b111, 1'b0, 1'b1, 2'd1, 32'd2);
    chk("ch1_pending", bus.pending, 3'b010);
    bus.load_valid = 1'b0; bus.load_ch = 2'd1;
    #1;
    chk("ch1_not_ready", {2'b00, bus.load_ready}, 3'b000);
    idle(9);

    // Pause ch2 for three cycles.
    step(3'b111, 1'b0, 1'b0, 2'd0, 32'd0);
    repeat (3) step(3'b011, 1'b0, 1'b0, 2'd0, 32'd0);
    idle(8);

    // Disable ch0 with a zero divisor, then restart it with 5.
    step(3'b111, 1'b0, 1'b1, 2'd0, 32'd0);
    idle(7);
    step(3'b111, 1'b0, 1'b1, 2'd0, 32'd5);
    idle(5);
    chk("ch0_not_yet", {2'b00, bus.tick[0]}, 3'b000);
    idle(1);
    chk("ch0_restart_tick", {2'b00, bus.tick[0]}, 3'b001);
    idle(3);

    // Async reset with a staged ch1 write outstanding.
    step(3'b111, 1'b0, 1'b1, 2'd1, 32'd3);
    chk("pre_rst_pending1", {2'b00, bus.pending[1]}, 3'b001);
    #5;
    rst = 1'b1;
    bus.load_valid = 1'b1; bus.load_ch = 2'd3; bus.load_div = 32'd9;
    #1;
    chk("rst_tick", bus.tick, 3'b000);
    chk("rst_clk_out", bus.clk_out, 3'b000);
    chk("rst_pending", bus.pending, 3'b000);
    chk("oor_ready", {2'b00, bus.load_ready}, 3'b001);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.load_valid = 1'b0;

    // Sync coinciding with the default boundary, then an out-of-range write.
    idle(3);
    step(3'b111, 1'b1, 1'b0, 2'd0, 32'd0);
    chk("sync_no_tick", bus.tick, 3'b000);
    chk("sync_clk_out", bus.clk_out, 3'b000);
    step(3'b111, 1'b0, 1'b1, 2'd3, 32'd7);
    chk("oor_no_pending", bus.pending, 3'b000);
    idle(2);
    chk("post_sync_quiet", bus.tick, 3'b000);
    idle(1);
    chk("post_sync_tick", bus.tick, 3'b111);

    // Sync exactly on a ch0 boundary located through the model.
    guard = 0;
    while (m_rem[0] != 1 && guard < 20) begin
      idle(1);
      guard++;
    end
    chk("find_boundary", {2'b00, (guard < 20)}, 3'b001);
    step(3'b111, 1'b1, 1'b0, 2'd0, 32'd0);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      e  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
      s  = ($urandom_range(0, 60) == 0);
      lv = ($urandom_range(0, 4) == 0);
      lc = 2'($urandom_range(0, 3));
      ld = 32'($urandom_range(0, 6));
      step(e, s, lv, lc, ld);
    end

    chk("scoreboard_drained", 3'(sb.size()), 3'b000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
